// File: rtl/sr_readback_check.sv
// sr_readback_check
//   Captures the serial readback of the configuration shift register while a new
//   word is shifted in. Returned bits are reassembled LSB-first and compared on the
//   fly against a reference word latched at start.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   single-cycle capture request (ignored while busy)
//   dout_sr  in   serial bit returned from the chain
//   ref_word in   expected word; bit i compared with the i-th returned bit
//   busy     out  capture in progress
//   done     out  one-cycle completion pulse
//   match    out  last completed capture had zero mismatches
//   err_cnt  out  saturating mismatch count of current/last capture
//   dout     out  captured word; bit i is the i-th returned bit
module sr_readback_check #(
  parameter int unsigned DATA_WIDTH = 170,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned SKIP       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dout_sr,
  input  logic [DATA_WIDTH-1:0] ref_word,
  output logic                  busy,
  output logic                  done,
  output logic                  match,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [DATA_WIDTH-1:0] dout
);

  typedef enum logic [1:0] {StIdle, StSkip, StCapture} state_e;

  // SKIP == 0 never enters StSkip, so the value used for that case is irrelevant.
  localparam logic [CNT_WIDTH-1:0] SkipLast = (SKIP == 0) ? '0 : CNT_WIDTH'(SKIP - 1);
  localparam logic [CNT_WIDTH-1:0] DataLast = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] ErrMax   = '1;

  state_e                r_state, w_state;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt;
  logic [DATA_WIDTH-1:0] r_ref, w_ref;
  logic [DATA_WIDTH-1:0] r_dout, w_dout;
  logic [CNT_WIDTH-1:0]  r_err, w_err;
  logic                  r_match, w_match;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;

  logic [DATA_WIDTH-1:0] w_bit_mask;
  logic                  w_ref_bit;
  logic [CNT_WIDTH-1:0]  w_err_upd;

  always_comb begin
    w_bit_mask = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << r_cnt;
    w_ref_bit  = |(r_ref & w_bit_mask);
    // Mismatch count including the bit currently on dout_sr, saturating.
    if ((dout_sr != w_ref_bit) && (r_err != ErrMax)) begin
      w_err_upd = r_err + 1'b1;
    end else begin
      w_err_upd = r_err;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_ref   = r_ref;
    w_dout  = r_dout;
    w_err   = r_err;
    w_match = r_match;
    w_busy  = r_busy;
    w_done  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_ref   = ref_word;
          w_dout  = '0;
          w_err   = '0;
          w_match = 1'b0;
          w_cnt   = '0;
          w_busy  = 1'b1;
          w_state = (SKIP == 0) ? StCapture : StSkip;
        end
      end
      StSkip: begin
        if (r_cnt == SkipLast) begin
          w_cnt   = '0;
          w_state = StCapture;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      StCapture: begin
        // dout was cleared at start, so OR-ing in the set bits is enough.
        if (dout_sr) begin
          w_dout = r_dout | w_bit_mask;
        end
        w_err = w_err_upd;
        if (r_cnt == DataLast) begin
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_match = (w_err_upd == '0);
          w_cnt   = '0;
          w_state = StIdle;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state = StIdle;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_ref   <= '0;
      r_dout  <= '0;
      r_err   <= '0;
      r_match <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_ref   <= w_ref;
      r_dout  <= w_dout;
      r_err   <= w_err;
      r_match <= w_match;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign match   = r_match;
  assign err_cnt = r_err;
  assign dout    = r_dout;

endmodule

// File: tb/tb_sr_readback_check.sv
module tb_sr_readback_check;

  localparam int W  = 170;
  localparam int BS = 2;
  localparam int SW = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic          dout_sr;
  logic [W-1:0]  ref_word;
  logic          busy;
  logic          done;
  logic          match;
  logic [7:0]    err_cnt;
  logic [W-1:0]  dout;

  logic          s_start;
  logic          s_dout_sr;
  logic [SW-1:0] s_ref;
  logic          s_busy;
  logic          s_done;
  logic          s_match;
  logic [3:0]    s_err;
  logic [SW-1:0] s_dout;

  int n_checks;
  int n_fail;

  logic [W-1:0] pat_a;
  logic [W-1:0] flips;

  sr_readback_check #(.DATA_WIDTH(W), .CNT_WIDTH(8), .SKIP(BS)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dout_sr (dout_sr),
    .ref_word(ref_word),
    .busy    (busy),
    .done    (done),
    .match   (match),
    .err_cnt (err_cnt),
    .dout    (dout)
  );

  sr_readback_check #(.DATA_WIDTH(SW), .CNT_WIDTH(4), .SKIP(0)) u_small (
    .clk     (clk),
    .rst     (rst),
    .start   (s_start),
    .dout_sr (s_dout_sr),
    .ref_word(s_ref),
    .busy    (s_busy),
    .done    (s_done),
    .match   (s_match),
    .err_cnt (s_err),
    .dout    (s_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launches one capture on the big instance and shifts pat out LSB-first, bit i
  // presented before edge k+BS+1+i. Optionally injects a second start with a new
  // reference at j == alt_at, and a one-cycle reset at j == rst_at.
  task automatic drive_big(input logic [W-1:0] pat, input logic [W-1:0] refw,
                           input int alt_at, input logic [W-1:0] alt_ref, input int rst_at,
                           output int done_cyc, output int done_cnt, output int busy_cyc,
                           output bit rst_zero);
    done_cyc = -1;
    done_cnt = 0;
    busy_cyc = 0;
    rst_zero = 1'b0;
    ref_word = refw;
    dout_sr  = 1'b0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy) busy_cyc++;
    for (int j = 1; j <= 190; j++) begin
      start = (j == alt_at);
      if (j == alt_at) ref_word = alt_ref;
      rst = (j == rst_at);
      dout_sr = (j >= BS + 1 && j <= BS + W) ? pat[j-BS-1] : 1'b0;
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = j;
      end
      if (busy) busy_cyc++;
      if (j == rst_at) begin
        rst_zero = (busy === 1'b0) && (done === 1'b0) && (match === 1'b0) &&
                   (err_cnt === 8'd0) && (dout === '0);
      end
    end
    start   = 1'b0;
    rst     = 1'b0;
    dout_sr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %0b expected 0", match); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %0h expected 0", dout); end
    n_checks++; if (s_busy !== 1'b0 || s_dout !== 8'h00) begin
      n_fail++; $display("FAIL reset_small: got busy %0b dout %0h expected 0 0", s_busy, s_dout);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_zero_capture();
    int dc, dn, bc;
    bit rz;
    drive_big('0, '0, 0, '0, 0, dc, dn, bc, rz);
    n_checks++; if (dc !== 172) begin n_fail++; $display("FAIL zero_done_cycle: got %0d expected 172", dc); end
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL zero_done_count: got %0d expected 1", dn); end
    n_checks++; if (bc !== 172) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d expected 172", bc); end
    n_checks++; if (match !== 1'b1) begin n_fail++; $display("FAIL zero_match: got %0b expected 1", match); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL zero_err: got %0d expected 0", err_cnt); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL zero_dout: got %0h expected 0", dout); end
  endtask

  task automatic test_pattern_match();
    int dc, dn, bc;
    bit rz;
    drive_big(pat_a, pat_a, 0, '0, 0, dc, dn, bc, rz);
    n_checks++; if (dout !== pat_a) begin n_fail++; $display("FAIL pat_dout: got %0h expected %0h", dout, pat_a); end
    n_checks++; if (match !== 1'b1) begin n_fail++; $display("FAIL pat_match: got %0b expected 1", match); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL pat_err: got %0d expected 0", err_cnt); end
    n_checks++; if (dc !== 172) begin n_fail++; $display("FAIL pat_done_cycle: got %0d expected 172", dc); end
  endtask

  task automatic test_flipped_bits();
    int dc, dn, bc;
    bit rz;
    drive_big(pat_a, pat_a ^ flips, 0, '0, 0, dc, dn, bc, rz);
    n_checks++; if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL flip_err: got %0d expected 3", err_cnt); end
    n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL flip_match: got %0b expected 0", match); end
    n_checks++; if (dout !== pat_a) begin n_fail++; $display("FAIL flip_dout: got %0h expected %0h", dout, pat_a); end
  endtask

  task automatic test_ignored_start();
    int dc, dn, bc;
    bit rz;
    // Second start at k+50 carries a reference that would match perfectly.
    drive_big(pat_a, pat_a ^ flips, 50, pat_a, 0, dc, dn, bc, rz);
    n_checks++; if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL ign_err: got %0d expected 3", err_cnt); end
    n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL ign_match: got %0b expected 0", match); end
    n_checks++; if (dc !== 172) begin n_fail++; $display("FAIL ign_done_cycle: got %0d expected 172", dc); end
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d expected 1", dn); end
    n_checks++; if (bc !== 172) begin n_fail++; $display("FAIL ign_busy_cycles: got %0d expected 172", bc); end
  endtask

  task automatic test_reset_abort();
    int dc, dn, bc;
    bit rz;
    drive_big(pat_a, pat_a, 0, '0, 100, dc, dn, bc, rz);
    n_checks++; if (rz !== 1'b1) begin n_fail++; $display("FAIL abort_outputs_zero: got %0b expected 1", rz); end
    n_checks++; if (dn !== 0) begin n_fail++; $display("FAIL abort_done_count: got %0d expected 0", dn); end
    n_checks++; if (busy !== 1'b0 || dout !== '0) begin
      n_fail++; $display("FAIL abort_idle: got busy %0b dout %0h expected 0 0", busy, dout);
    end
    drive_big(pat_a, pat_a, 0, '0, 0, dc, dn, bc, rz);
    n_checks++; if (dc !== 172) begin n_fail++; $display("FAIL rerun_done_cycle: got %0d expected 172", dc); end
    n_checks++; if (match !== 1'b1 || dout !== pat_a) begin
      n_fail++; $display("FAIL rerun_result: got match %0b dout %0h expected 1 %0h", match, dout, pat_a);
    end
  endtask

  task automatic test_all_ones();
    int dc, dn, bc;
    bit rz;
    drive_big('0, '1, 0, '0, 0, dc, dn, bc, rz);
    n_checks++; if (err_cnt !== 8'd170) begin n_fail++; $display("FAIL ones_err: got %0d expected 170", err_cnt); end
    n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL ones_match: got %0b expected 0", match); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL ones_dout: got %0h expected 0", dout); end
  endtask

  task automatic test_back_to_back();
    int dc;
    s_ref     = 8'h55;
    s_dout_sr = 1'b0;
    s_start   = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    dc = -1;
    for (int j = 1; j <= 8; j++) begin
      s_dout_sr = ((j - 1) % 2 == 0);
      @(posedge clk); #1;
      if (s_done && dc < 0) dc = j;
    end
    n_checks++; if (dc !== 8) begin n_fail++; $display("FAIL small_done_cycle: got %0d expected 8", dc); end
    n_checks++; if (s_dout !== 8'h55) begin n_fail++; $display("FAIL small_dout: got %0h expected 55", s_dout); end
    n_checks++; if (s_match !== 1'b1 || s_err !== 4'd0) begin
      n_fail++; $display("FAIL small_match: got %0b err %0d expected 1 0", s_match, s_err);
    end
    // Start while done is high: accepted on the next edge.
    s_ref     = 8'h00;
    s_dout_sr = 1'b0;
    s_start   = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    n_checks++; if (s_busy !== 1'b1 || s_done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_busy: got busy %0b done %0b expected 1 0", s_busy, s_done);
    end
    dc = -1;
    for (int j = 1; j <= 12; j++) begin
      s_dout_sr = 1'b0;
      @(posedge clk); #1;
      if (s_done && dc < 0) dc = j;
    end
    n_checks++; if (dc !== 8) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d expected 8", dc); end
    n_checks++; if (s_dout !== 8'h00 || s_match !== 1'b1) begin
      n_fail++; $display("FAIL b2b_result: got dout %0h match %0b expected 0 1", s_dout, s_match);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    dout_sr   = 1'b0;
    ref_word  = '0;
    s_start   = 1'b0;
    s_dout_sr = 1'b0;
    s_ref     = '0;
    for (int i = 0; i < W; i++) pat_a[i] = (i % 2 == 1);
    flips     = '0;
    flips[0]  = 1'b1;
    flips[85] = 1'b1;
    flips[169] = 1'b1;

    test_reset();
    test_zero_capture();
    test_pattern_match();
    test_flipped_bits();
    test_ignored_start();
    test_reset_abort();
    test_all_ones();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_readback_check.md
# sr_readback_check

Serial readback capture-and-compare stage for the TMIIa configuration shift register. It sits directly downstream of the shift-register write controller. It shares that controller's `start` pulse and samples the chip's serial shift-register output (`dout_sr`), which presents the previous contents of the chain as the new word is shifted in. It reassembles the returned bits LSB-first into a `DATA_WIDTH` word and counts bit mismatches against a reference word on the fly. It reports `done`, `match` and an error count to the host register interface.

## Interface
- `DATA_WIDTH`, 170, number of shift-register bits to capture
- `CNT_WIDTH`, 8, width of the bit/skip counter and `err_cnt`; requires 2^CNT_WIDTH > DATA_WIDTH and > SKIP
- `SKIP`, 2, clk cycles between accepted `start` and the first valid `dout_sr` bit; 0 allowed

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle request; same pulse that launches the write controller
- `dout_sr`  in  1  serial data returned from the chip shift-register chain
- `ref_word`  in  DATA_WIDTH  expected readback word; bit i is compared with the i-th returned bit
- `busy`  out  1  high while a capture is in progress
- `done`  out  1  one-cycle pulse when the capture completes
- `match`  out  1  1 when the last completed capture had zero mismatches; held until the next accepted start
- `err_cnt`  out  CNT_WIDTH  mismatch count of the current or last capture
- `dout`  out  DATA_WIDTH  captured word; bit i is the i-th returned bit

## Operation
- States: IDLE, SKIP, CAPTURE. Counter `cnt` (CNT_WIDTH) is shared by SKIP and CAPTURE.
- IDLE → `start`=1:
  - latch `ref_word` into internal `ref_q`
  - clear `dout`, `err_cnt`, `match`, `cnt`
  - set `busy`=1
  - go to SKIP, or directly to CAPTURE if SKIP=0
- SKIP:
  - `cnt` increments each cycle
  - when `cnt`==SKIP-1, clear `cnt` and go to CAPTURE
- CAPTURE, each cycle:
  - `dout[cnt]` <= `dout_sr`
  - if `dout_sr` != `ref_q[cnt]`, `err_cnt` <= `err_cnt`+1, saturating at 2^CNT_WIDTH-1
  - `cnt` increments
- CAPTURE at `cnt`==DATA_WIDTH-1 (last bit):
  - take the final sample and compare as above
  - `done` <= 1, `busy` <= 0
  - `match` <= 1 iff the final `err_cnt` value (including this bit) is 0
  - return to IDLE
- `start` while `busy`=1 is ignored; the capture continues unaffected.
- `ref_word` changes after acceptance have no effect, because `ref_q` is used.
- `dout`, `err_cnt` and `match` hold their values in IDLE until the next accepted `start`.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `match`=0
  - `err_cnt`=0, `dout`=0, `ref_q`=0
  - state=IDLE, `cnt`=0
- Reset asserted mid-capture aborts immediately to these values. No `done` is produced for the aborted capture.
- Let k be the rising edge at which `start`=1 is sampled in IDLE:
  - `busy` goes high after edge k
  - bit i (i = 0..DATA_WIDTH-1) is sampled at edge k+SKIP+1+i
- Completion at edge k+SKIP+DATA_WIDTH:
  - `dout`, `err_cnt` and `match` take their final values
  - `done`=1 and `busy`=0 for exactly one cycle
- Total latency from `start` to `done` is SKIP+DATA_WIDTH cycles. The default is 172.
- `start` sampled in the same cycle that `done`=1 is accepted, because the block is already in IDLE. Back-to-back captures therefore have zero dead cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then pulse `start` with `ref_word`=all-zeros and `dout_sr`=0 → `done` exactly 172 cycles later; `match`=1; `err_cnt`=0; `dout`=0; `busy` high for exactly 172 cycles.
- Drive `dout_sr` from a model shifting out 170'h2AAAA…A (LSB-first) with `ref_word` equal to it → `dout`=that value, `match`=1. Flip bits 0, 85 and 169 of `ref_word` → `err_cnt`=3, `match`=0.
- Change `ref_word` and pulse `start` again at cycle k+50 of a running capture → both ignored; results match the originally latched reference; `done` still at k+172.
- Assert `rst` at cycle k+100 → all outputs 0 on the next cycle, no `done` pulse. A fresh `start` after release completes normally.
- SKIP=0, DATA_WIDTH=8 with `dout_sr` toggling 1,0,1,0… → `dout`=8'h55 and `done` 8 cycles after `start`. A `start` coincident with `done` launches a second capture with `busy` high on the next cycle.
- `ref_word`=all-ones, `dout_sr`=0 for all 170 bits → `err_cnt`=170, `match`=0, no saturation.
